// File: rtl/mult_booth4_seq_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier.
// Holds the FSM state encoding, the decoded Booth digit and the counter sizing.
// Also imported by the parallel Booth partial-product generators.
package mult_booth4_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // One radix-4 Booth digit: magnitude is one or two times A, sign in neg.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // The counter covers WIDTH/2+1 digits with headroom for the terminal value.
  function automatic int cnt_width(input int width);
    return $clog2(width / 2 + 2);
  endfunction

endpackage

// File: rtl/mult_booth4_seq_if.sv
// Operand/product handshake bundle for the iterative Booth multiplier.
// master = upstream/downstream side, slave = multiplier side.
// Both directions use valid/ready; the producer holds data until accepted.
interface mult_booth4_seq_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, multiplicand, multiplier, is_signed, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, is_signed, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/mult_booth4_seq_digit_enc.sv
// Radix-4 Booth recoder: 3-bit window {b[2i+1], b[2i], b[2i-1]} -> digit.
// Purely combinational, zero latency.
// No handshake; the caller owns the window register.
module booth4_digit_enc
  import mult_booth4_seq_pkg::*;
(
  input  logic [2:0]   window,
  output booth_digit_t digit
);

  // Map each window onto {0, +1, +2, -2, -1}; 000 and 111 both mean zero.
  always_comb begin
    digit = '0;
    case (window)
      3'b001, 3'b010: digit.one = 1'b1;
      3'b011:         digit.two = 1'b1;
      3'b100:         begin digit.neg = 1'b1; digit.two = 1'b1; end
      3'b101, 3'b110: begin digit.neg = 1'b1; digit.one = 1'b1; end
      default:        digit = '0;
    endcase
  end

endmodule

// File: rtl/mult_booth4_seq.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, signed/unsigned per op.
// Latency: accept at edge T -> out_valid after edge T+WIDTH/2+1.
// Backpressure: in_ready only in IDLE; the product is held in DONE until out_ready.
module mult_booth4_seq
  import mult_booth4_seq_pkg::*;
#(
  parameter int WIDTH = 16  // even and >= 4
) (
  input logic              clk,
  input logic              rst_n,
  mult_booth4_seq_if.slave bus
);

  localparam int DIGITS = WIDTH / 2 + 1;
  localparam int ACC_W  = 2 * WIDTH + 2;
  localparam int B_W    = WIDTH + 3;  // B extended to WIDTH+2 plus the implicit B[-1]
  localparam int CNT_W  = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     a_sh;    // A * 4^cnt, sign/zero extended to the accumulator width
  logic [B_W-1:0]       b_sh;    // B shifted right by 2 per digit; low 3 bits are the window
  logic [2*WIDTH-1:0]   product_q;
  logic                 out_valid_q;

  booth_digit_t         dig;
  logic                 a_sx;
  logic                 b_sx;
  logic [ACC_W-1:0]     a_load;
  logic [B_W-1:0]       b_load;
  logic [ACC_W-1:0]     multiple;
  logic [ACC_W-1:0]     addend;
  logic [ACC_W-1:0]     acc_next;

  // Extension bits are sign copies only in signed mode, so one path serves both.
  assign a_sx   = bus.is_signed & bus.multiplicand[WIDTH-1];
  assign b_sx   = bus.is_signed & bus.multiplier[WIDTH-1];
  assign a_load = {{(ACC_W - WIDTH){a_sx}}, bus.multiplicand};
  assign b_load = {{2{b_sx}}, bus.multiplier, 1'b0};

  booth4_digit_enc u_enc (
    .window (b_sh[2:0]),
    .digit  (dig)
  );

  // Negative digits reuse the adder: acc + ~multiple + 1.
  assign multiple = dig.two ? {a_sh[ACC_W-2:0], 1'b0} :
                    dig.one ? a_sh : '0;
  assign addend   = dig.neg ? ~multiple : multiple;
  assign acc_next = acc + addend + ACC_W'(dig.neg);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

  // Control FSM plus operand, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= a_load;
            b_sh  <= b_load;
            acc   <= '0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc  <= acc_next;
          a_sh <= {a_sh[ACC_W-3:0], 2'b00};
          b_sh <= {{2{b_sh[B_W-1]}}, b_sh[B_W-1:2]};
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            // Take the sum including the final digit, not the stale accumulator.
            product_q   <= acc_next[2*WIDTH-1:0];
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
